// File: rtl/drext_pkg.sv
// Shared types and helpers for the data-read extension unit.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package drext_pkg;

    typedef enum logic [1:0] {
        SZ_WORD = 2'd0,
        SZ_HALF = 2'd1,
        SZ_BYTE = 2'd2
    } acc_size_e;

    localparam int BYTE_W = 8;
    localparam int HALF_W = 16;

    // Byte wins over halfword when both flags are raised.
    function automatic acc_size_e decode_size(input logic is_byte, input logic is_half);
        acc_size_e sz;
        if (is_byte) begin
            sz = SZ_BYTE;
        end else if (is_half) begin
            sz = SZ_HALF;
        end else begin
            sz = SZ_WORD;
        end
        return sz;
    endfunction

endpackage

// File: rtl/drext_lane_sel.sv
// Lane mux plus zero/sign extender for byte, halfword and word loads.
// Latency: purely combinational, zero cycles.
// Backpressure: none; output follows inputs continuously.
//
// Ports: in_data (raw word), low_addr (addr[1:0]), size (decoded access size),
//        exsign (1 = sign-extend), out_data (extended result).
module drext_lane_sel
    import drext_pkg::*;
#(
    parameter int DW = 32
) (
    input  logic [DW-1:0] in_data,
    input  logic [1:0]    low_addr,
    input  acc_size_e     size,
    input  logic          exsign,
    output logic [DW-1:0] out_data
);

    logic [BYTE_W-1:0] lane_b;
    logic [HALF_W-1:0] lane_h;

    always_comb begin
        lane_b = in_data[7:0];
        case (low_addr)
            2'd0:    lane_b = in_data[7:0];
            2'd1:    lane_b = in_data[15:8];
            2'd2:    lane_b = in_data[23:16];
            default: lane_b = in_data[31:24];
        endcase

        // low_addr[0] is deliberately ignored for halfwords; the misalign
        // flag reports that case instead of shifting the lane.
        lane_h = low_addr[1] ? in_data[31:16] : in_data[15:0];

        out_data = in_data;
        case (size)
            SZ_BYTE: out_data = {{(DW-BYTE_W){exsign & lane_b[BYTE_W-1]}}, lane_b};
            SZ_HALF: out_data = {{(DW-HALF_W){exsign & lane_h[HALF_W-1]}}, lane_h};
            default: out_data = in_data;
        endcase
    end

endmodule

// File: rtl/drext_unit.sv
// MEM-stage load extraction/extension with misalign flag and sticky misalign status.
// Latency: out_data/misalign combinational (1 cycle when DREXT_OUT_REG_EN is defined).
// Backpressure: none; result is valid whenever inputs are.
//
// Optional feature macro: DREXT_OUT_REG_EN registers out_data and misalign.
// Ports: clk, rst (async active-low), in_data, low_addr, exsign, isByte, isHalf,
//        rd_en (qualifies status update), err_clr (sync clear of sticky),
//        out_data, misalign, misalign_sticky.
module drext_unit
    import drext_pkg::*;
#(
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] in_data,
    input  logic [1:0]    low_addr,
    input  logic          exsign,
    input  logic          isByte,
    input  logic          isHalf,
    input  logic          rd_en,
    input  logic          err_clr,
    output logic [DW-1:0] out_data,
    output logic          misalign,
    output logic          misalign_sticky
);

    acc_size_e     size;
    logic [DW-1:0] ext_data;
    logic          mis_c;
    logic          sticky_set;

    assign size = decode_size(isByte, isHalf);

    drext_lane_sel #(
        .DW (DW)
    ) u_lane_sel (
        .in_data  (in_data),
        .low_addr (low_addr),
        .size     (size),
        .exsign   (exsign),
        .out_data (ext_data)
    );

    always_comb begin
        mis_c = 1'b0;
        case (size)
            SZ_HALF: mis_c = low_addr[0];
            SZ_WORD: mis_c = (low_addr != 2'd0);
            default: mis_c = 1'b0;
        endcase
    end

`ifdef DREXT_OUT_REG_EN
    logic rd_en_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_data <= '0;
            misalign <= 1'b0;
            rd_en_q  <= 1'b0;
        end else begin
            out_data <= ext_data;
            misalign <= mis_c;
            rd_en_q  <= rd_en;
        end
    end

    // Status tracks the registered view so it lines up with the delayed result.
    assign sticky_set = rd_en_q & misalign;
`else
    assign out_data   = ext_data;
    assign misalign   = mis_c;
    assign sticky_set = rd_en & mis_c;
`endif

    // Clear wins over set so software can acknowledge while faults continue.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            misalign_sticky <= 1'b0;
        end else if (err_clr) begin
            misalign_sticky <= 1'b0;
        end else if (sticky_set) begin
            misalign_sticky <= 1'b1;
        end
    end

endmodule

// File: tb/tb_drext_unit.sv
// Self-checking bench for drext_unit (default combinational build).
// Latency: n/a (bench).
// Backpressure: n/a (bench).
module tb_drext_unit;

    logic        clk;
    logic        rst;
    logic [31:0] in_data;
    logic [1:0]  low_addr;
    logic        exsign;
    logic        isByte;
    logic        isHalf;
    logic        rd_en;
    logic        err_clr;
    logic [31:0] out_data;
    logic        misalign;
    logic        misalign_sticky;

    int checks = 0;
    int errors = 0;
    logic m_sticky;

    drext_unit #(.DW(32)) dut (
        .clk             (clk),
        .rst             (rst),
        .in_data         (in_data),
        .low_addr        (low_addr),
        .exsign          (exsign),
        .isByte          (isByte),
        .isHalf          (isHalf),
        .rd_en           (rd_en),
        .err_clr         (err_clr),
        .out_data        (out_data),
        .misalign        (misalign),
        .misalign_sticky (misalign_sticky)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference result from the access rules, using shifts and masks.
    function automatic logic [31:0] m_out(input logic [31:0] d, input logic [1:0] a,
                                          input logic s, input logic b, input logic h);
        logic [31:0] v;
        if (b) begin
            v = (d >> (8 * int'(a))) & 32'h0000_00FF;
            if (s && v[7]) v = v | 32'hFFFF_FF00;
        end else if (h) begin
            v = (d >> (16 * int'(a[1]))) & 32'h0000_FFFF;
            if (s && v[15]) v = v | 32'hFFFF_0000;
        end else begin
            v = d;
        end
        return v;
    endfunction

    function automatic logic m_mis(input logic [1:0] a, input logic b, input logic h);
        if (b) return 1'b0;
        if (h) return a[0];
        return (a != 2'd0);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Sticky status model: a flag raised by any qualified misaligned load.
    always @(posedge clk or negedge rst) begin
        if (!rst)                                      m_sticky <= 1'b0;
        else if (err_clr)                              m_sticky <= 1'b0;
        else if (rd_en && m_mis(low_addr, isByte, isHalf)) m_sticky <= 1'b1;
    end

    // Continuous comparison against the model on every falling edge.
    always @(negedge clk) begin
        check("model_out", out_data, m_out(in_data, low_addr, exsign, isByte, isHalf));
        check("model_mis", {31'd0, misalign}, {31'd0, m_mis(low_addr, isByte, isHalf)});
        check("model_sticky", {31'd0, misalign_sticky}, {31'd0, m_sticky});
    end

    task automatic drive(input logic [31:0] d, input logic [1:0] a, input logic s,
                         input logic b, input logic h, input logic re, input logic clr);
        @(posedge clk);
        #1;
        in_data  = d;
        low_addr = a;
        exsign   = s;
        isByte   = b;
        isHalf   = h;
        rd_en    = re;
        err_clr  = clr;
    endtask

    // Apply one vector and compare to hand-computed literals.
    task automatic vec(input string name, input logic [31:0] d, input logic [1:0] a,
                       input logic s, input logic b, input logic h,
                       input logic [31:0] exp_out, input logic exp_mis);
        drive(d, a, s, b, h, 1'b0, 1'b0);
        @(negedge clk);
        check({name, "_out"}, out_data, exp_out);
        check({name, "_mis"}, {31'd0, misalign}, {31'd0, exp_mis});
    endtask

    initial begin
        rst      = 1'b0;
        in_data  = '0;
        low_addr = '0;
        exsign   = 1'b0;
        isByte   = 1'b0;
        isHalf   = 1'b0;
        rd_en    = 1'b0;
        err_clr  = 1'b0;
        #2;
        check("reset_sticky", {31'd0, misalign_sticky}, 32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;

        vec("byte_s0", 32'h8076F501, 2'd0, 1'b1, 1'b1, 1'b0, 32'h0000_0001, 1'b0);
        vec("byte_s1", 32'h8076F501, 2'd1, 1'b1, 1'b1, 1'b0, 32'hFFFF_FFF5, 1'b0);
        vec("byte_s2", 32'h8076F501, 2'd2, 1'b1, 1'b1, 1'b0, 32'h0000_0076, 1'b0);
        vec("byte_s3", 32'h8076F501, 2'd3, 1'b1, 1'b1, 1'b0, 32'hFFFF_FF80, 1'b0);
        vec("byte_z1", 32'h8076F501, 2'd1, 1'b0, 1'b1, 1'b0, 32'h0000_00F5, 1'b0);
        vec("half_s0", 32'h9ABC1234, 2'd0, 1'b1, 1'b0, 1'b1, 32'h0000_1234, 1'b0);
        vec("half_s2", 32'h9ABC1234, 2'd2, 1'b1, 1'b0, 1'b1, 32'hFFFF_9ABC, 1'b0);
        vec("half_z2", 32'h9ABC1234, 2'd2, 1'b0, 1'b0, 1'b1, 32'h0000_9ABC, 1'b0);
        vec("half_mis", 32'h9ABC1234, 2'd1, 1'b1, 1'b0, 1'b1, 32'h0000_1234, 1'b1);
        vec("word_a0", 32'hDEADBEEF, 2'd0, 1'b1, 1'b0, 1'b0, 32'hDEAD_BEEF, 1'b0);
        vec("word_a2", 32'hDEADBEEF, 2'd2, 1'b1, 1'b0, 1'b0, 32'hDEAD_BEEF, 1'b1);
        vec("prio_b3", 32'hDEADBEEF, 2'd3, 1'b1, 1'b1, 1'b1, 32'hFFFF_FFDE, 1'b0);
        vec("prio_z3", 32'hDEADBEEF, 2'd3, 1'b0, 1'b1, 1'b1, 32'h0000_00DE, 1'b0);
        check("sticky_idle", {31'd0, misalign_sticky}, 32'd0);

        // Misaligned halfword load with rd_en sets the sticky bit.
        drive(32'h9ABC1234, 2'd1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        @(negedge clk);
        check("pre_set_sticky", {31'd0, misalign_sticky}, 32'd0);
        drive(32'h9ABC1234, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        check("set_sticky", {31'd0, misalign_sticky}, 32'd1);
        drive(32'h9ABC1234, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        check("hold_sticky", {31'd0, misalign_sticky}, 32'd1);

        // Clear wins over a simultaneous qualified misaligned access.
        drive(32'h9ABC1234, 2'd1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
        drive(32'h9ABC1234, 2'd1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        check("clr_prio", {31'd0, misalign_sticky}, 32'd0);

        // Unqualified misaligned access must not set.
        drive(32'hDEADBEEF, 2'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        check("no_rden", {31'd0, misalign_sticky}, 32'd0);

        // Set again, then pull reset between edges.
        drive(32'hDEADBEEF, 2'd1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        drive(32'hDEADBEEF, 2'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        check("reset_pre", {31'd0, misalign_sticky}, 32'd1);
        #2 rst = 1'b0;
        #1;
        check("async_rst_sticky", {31'd0, misalign_sticky}, 32'd0);
        check("async_rst_out", out_data, 32'hDEAD_BEEF);
        check("async_rst_mis", {31'd0, misalign}, 32'd1);
        @(posedge clk);
        #1 rst = 1'b1;

        // A few more model-checked patterns.
        drive(32'h7F80_00FF, 2'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        drive(32'h7F80_00FF, 2'd2, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        drive(32'h7F80_00FF, 2'd3, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        drive(32'h0000_0000, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        check("final_sticky", {31'd0, misalign_sticky}, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/drext_unit.md
Name: drext_unit

Overview:
Data-read extension unit for the MEM stage of the pipelined CPU. It takes the raw 32-bit word read from data memory or the bridge and extracts the addressed byte or halfword, then zero- or sign-extends it to 32 bits for write-back. The data path is combinational. A small clocked block keeps a sticky misalignment status for debug and exception logic.

Parameters:
DW, 32, data width; only 32 is supported.

Ports:
clk  in  1  system clock
rst  in  1  reset; asynchronous, active-low
in_data  in  32  raw word from DM or bridge (PrRD)
low_addr  in  2  effective address bits [1:0] (EXout[1:0])
exsign  in  1  1 = sign-extend, 0 = zero-extend (load-signed flag)
isByte  in  1  byte access
isHalf  in  1  halfword access
rd_en  in  1  qualifies a real load this cycle; used only by the status logic
err_clr  in  1  synchronous clear of the sticky error
out_data  out  32  extracted and extended result
misalign  out  1  combinational: current access is misaligned
misalign_sticky  out  1  registered: a qualified misaligned access has occurred

Behaviour:
- Access size decode:
  - isByte=1 selects byte, with priority over isHalf.
  - Otherwise isHalf=1 selects halfword.
  - Otherwise the access is a word.
- Byte lane selection is little-endian:
  - low_addr 0 -> in_data[7:0]
  - low_addr 1 -> in_data[15:8]
  - low_addr 2 -> in_data[23:16]
  - low_addr 3 -> in_data[31:24]
- Byte extension: exsign=1 replicates bit 7 of the lane into [31:8]; exsign=0 zero-fills [31:8].
- Halfword lane selection: low_addr[1]=0 -> in_data[15:0]; low_addr[1]=1 -> in_data[31:16]. low_addr[0] is ignored for lane selection.
- Halfword extension: exsign=1 replicates bit 15 into [31:16]; otherwise [31:16] is zero.
- Word access: out_data = in_data. low_addr and exsign are ignored.
- misalign (combinational):
  - halfword with low_addr[0]=1 -> 1
  - word with low_addr != 0 -> 1
  - byte -> always 0
- out_data and misalign are purely combinational, zero latency, and independent of clk and rst.
- misalign_sticky:
  - Reset value is 0.
  - On a clk rising edge: err_clr=1 forces it to 0, with priority over a set.
  - Otherwise rd_en & misalign sets it to 1.
  - Otherwise it holds.
- Reset asserted mid-operation clears misalign_sticky immediately (asynchronous) and does not affect out_data.
- No X propagation: every combination of isByte, isHalf, low_addr and exsign yields a defined output.

Optional Feature:
DREXT_OUT_REG_EN
- Defined:
  - out_data and misalign are registered on clk with 1-cycle latency and reset to 0.
  - misalign_sticky uses the registered misalign together with rd_en delayed by one cycle.
- Undefined: out_data and misalign are combinational as described above. This is the default build used by MEM, where the value feeds WB_Wd in the same cycle.

Decomposition:
- Package drext_pkg contains:
  - enum acc_size_e {SZ_WORD, SZ_HALF, SZ_BYTE}
  - localparams for lane widths (BYTE_W=8, HALF_W=16)
  - function decode_size(isByte, isHalf) returning acc_size_e
- One natural sub-module, drext_lane_sel: a pure-combinational lane mux plus extender taking in_data, low_addr, size and exsign, producing out_data.
- drext_unit wraps drext_lane_sel with the misalign decode, the sticky register and the optional output register.

Test Plan:
- Byte sign extension: in_data=0x8076F501, isByte=1, exsign=1, sweep low_addr 0..3 -> out_data 0x00000001, 0xFFFFFFF5, 0x00000076, 0xFFFFFF80; misalign=0.
- Byte zero extension: same in_data, exsign=0, low_addr=1 -> out_data 0x000000F5.
- Halfword, aligned: in_data=0x9ABC1234, isHalf=1:
  - low_addr=0, exsign=1 -> 0x00001234
  - low_addr=2, exsign=1 -> 0xFFFF9ABC
  - low_addr=2, exsign=0 -> 0x00009ABC
- Word and priority:
  - isByte=isHalf=0, in_data=0xDEADBEEF, low_addr=0, exsign=1 -> 0xDEADBEEF, misalign=0.
  - isByte=isHalf=1, low_addr=3 -> treated as byte: 0xFFFFFFDE with exsign=1.
- Misalignment sticky:
  - isHalf=1, low_addr=1, rd_en=1 for one clk -> misalign=1; misalign_sticky=1 after the edge and held.
  - err_clr=1 with the same misaligned access -> misalign_sticky=0.
  - rd_en=0 with a misaligned access -> no set.
- Reset: set misalign_sticky, then assert rst=0 between clock edges -> misalign_sticky drops to 0 immediately; out_data is unchanged for the same inputs.
